mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Memory-stage access sequencer between the EX_MEM pipeline register and a byte-wide data RAM (8-bit data port, combinational read, write on clock edge). It turns a byte or word load/store request into 1 or 4 single-byte RAM transactions, using big-endian byte order. It stalls the pipeline while busy and hands the assembled load data to the MEM_WB path.

Parameters:
ADDR_W, 8, byte-address width of the data RAM.
BIG_ENDIAN, 1, 1 = byte at base+0 maps to data[31:24]; 0 = byte at base+0 maps to data[7:0].

Ports:
clk  in  1  pipeline clock; all state changes on rising edge.
R  in  1  reset; synchronous, active-high.
req_E  in  1  memory request valid (EX_MEM Enable_signal).
req_RW  in  1  0 = read, 1 = write.
req_Size  in  1  0 = byte, 1 = word.
req_A  in  ADDR_W  byte address.
req_DI  in  32  store data.
stall  out  1  hold IF/ID/EX/EX_MEM (drives the LE-disable path).
done  out  1  one-cycle pulse when the access completes.
misalign  out  1  valid with done; word request had req_A[1:0] != 0.
rd_data  out  32  assembled load data; held until the next read completes.
m_E  out  1  RAM enable.
m_RW  out  1  RAM read/write.
m_A  out  ADDR_W  RAM byte address.
m_DI  out  8  RAM write byte.
m_DO  in  8  RAM read byte (combinational).

Behaviour:
- States: IDLE, XFER, DONE. Registers: base address, size, rw, store data, cnt (2 bits), rd_data.
- Reset (R=1 at edge): state IDLE, cnt 0, rd_data 0, done 0, misalign 0. stall=0 and m_E=0 while R=1. m_E is gated by ~R, so no RAM write occurs at the reset edge.
- IDLE, req_E=1:
  - stall=1 combinationally.
  - At the edge: capture req_*, base = req_A with [1:0] cleared when word; base = req_A when byte.
  - Set the misalign flag register; cnt=0; go to XFER.
- IDLE, req_E=0: stall=0, m_E=0.
- XFER:
  - Drive m_E=1, m_RW=rw, m_A=base+cnt (mod 2^ADDR_W).
  - m_DI = the selected store byte: for word, lane cnt per BIG_ENDIAN; for byte, req_DI[7:0].
  - stall=1.
  - Read: at the edge, m_DO is written into the byte lane of rd_data selected by cnt. A byte read zero-extends to rd_data[31:8]=0 and lands in [7:0].
  - Last byte (cnt==0 for byte, cnt==3 for word): go to DONE; otherwise cnt++.
- DONE:
  - done=1, misalign valid, stall=0, m_E=0.
  - The pipeline advances at this edge. req_E seen in DONE is the completed request and is ignored. Always return to IDLE.
- Latency from request entry to done: byte 2 cycles, word 5 cycles. Stall cycles: byte 2, word 5.
- Back-to-back requests: a new request is accepted in the IDLE cycle right after DONE.
- Writes leave rd_data unchanged. During a read, rd_data lanes change progressively; they are only guaranteed valid when done=1.
- Reset mid-operation: bytes already written stay written, later bytes are not written, and the FSM returns to IDLE.

Test Plan:
- RAM[52..55]=12,34,56,78; word read A=52 → m_A 52,53,54,55 on consecutive cycles; done on cycle 5; rd_data=0x12345678; misalign=0; stall high exactly 5 cycles.
- Byte read A=56 with RAM[56]=0xF0 → rd_data=0x000000F0; done on cycle 2; stall 2 cycles.
- Byte write A=58, DI=0xDEADBEAB → RAM[58]=0xAB; RAM[57] and RAM[59] unchanged; rd_data unchanged.
- Word read A=53 → accesses 52..55; rd_data=0x12345678; misalign=1 with done.
- Word write A=0, DI=0xAABBCCDD, R=1 asserted after 2 XFER cycles → RAM[0]=AA, RAM[1]=BB, RAM[2..3] untouched; stall=0 and m_E=0 in the reset cycle; IDLE afterwards.
- Word read A=52 with req_E held, then byte read A=57 → second request accepted in the cycle after the first done; no request dropped or duplicated.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response and byte-RAM bundle for the memory-stage sequencer.
// Slave side is the sequencer; master side is pipeline plus RAM.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req_E;
  logic              req_RW;
  logic              req_Size;
  logic [ADDR_W-1:0] req_A;
  logic [31:0]       req_DI;
  logic              stall;
  logic              done;
  logic              misalign;
  logic [31:0]       rd_data;
  logic              m_E;
  logic              m_RW;
  logic [ADDR_W-1:0] m_A;
  logic [7:0]        m_DI;
  logic [7:0]        m_DO;

  modport slave (
    input  req_E, req_RW, req_Size, req_A, req_DI, m_DO,
    output stall, done, misalign, rd_data,
    output m_E, m_RW, m_A, m_DI
  );

  modport master (
    output req_E, req_RW, req_Size, req_A, req_DI, m_DO,
    input  stall, done, misalign, rd_data,
    input  m_E, m_RW, m_A, m_DI
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: splits byte/word loads and stores
// into single-byte RAM transactions and stalls the pipe meanwhile.
module mem_access_ctrl #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              R,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] base_q;
  logic              size_q;
  logic              rw_q;
  logic [31:0]       di_q;
  logic [1:0]        cnt_q;
  logic [31:0]       rd_q;
  logic              mis_q;

  logic              stall_c;
  logic              me_c;
  logic              done_c;
  logic              last;
  logic [1:0]        lane;

  assign lane = BIG_ENDIAN ? (2'd3 - cnt_q) : cnt_q;
  assign last = size_q ? (cnt_q == 2'd3) : 1'b1;

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    me_c    = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_E) begin
          stall_c = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        stall_c = 1'b1;
        me_c    = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks the enable so an interrupted store stops cleanly
  assign bus.stall    = stall_c & ~R;
  assign bus.m_E      = me_c & ~R;
  assign bus.m_RW     = rw_q & me_c & ~R;
  assign bus.done     = done_c & ~R;
  assign bus.misalign = done_c & ~R & mis_q;
  assign bus.rd_data  = rd_q;
  assign bus.m_A      = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
  assign bus.m_DI     = size_q ? di_q[{lane, 3'b000} +: 8]
                               : di_q[7:0];

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rd_q    <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_E) begin
        size_q <= bus.req_Size;
        rw_q   <= bus.req_RW;
        di_q   <= bus.req_DI;
        cnt_q  <= 2'd0;
        mis_q  <= bus.req_Size & (|bus.req_A[1:0]);
        base_q <= bus.req_Size
                  ? {bus.req_A[ADDR_W-1:2], 2'b00}
                  : bus.req_A;
      end
      if (state_q == XFER) begin
        if (!rw_q) begin
          if (size_q) rd_q[{lane, 3'b000} +: 8] <= bus.m_DO;
          else        rd_q <= {24'd0, bus.m_DO};
        end
        if (!last) cnt_q <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-wide RAM model.
// Vector table for single accesses, hand sequences for reset and back-to-back.
module tb_mem_access_ctrl;

  logic clk;
  logic R;
  logic       pre_we;
  logic [7:0] pre_a;
  logic [7:0] pre_d;
  logic [7:0] ram [0:255];

  int checks;
  int failures;

  mem_access_ctrl_if #(.ADDR_W(8)) bus ();

  mem_access_ctrl #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.m_DO = ram[bus.m_A];

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (bus.m_E && bus.m_RW) ram[bus.m_A] <= bus.m_DI;
  end

  typedef struct {
    logic        rw;
    logic        size;
    logic [7:0]  a;
    logic [31:0] di;
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          exp_lat;
    logic [7:0]  exp_a0;
    int          exp_n;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  // Entered #1 after a rising edge with the FSM in IDLE
  task automatic run_req(input logic rw, input logic size,
                         input logic [7:0] a, input logic [31:0] di,
                         input logic [7:0] a0,
                         output int lat, output int stalls,
                         output int nacc, output int aerr,
                         output logic mis, output logic [31:0] rd);
    bus.req_E    = 1'b1;
    bus.req_RW   = rw;
    bus.req_Size = size;
    bus.req_A    = a;
    bus.req_DI   = di;
    lat = -1; stalls = 0; nacc = 0; aerr = 0;
    mis = 1'bx; rd = 'x;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (bus.m_E) begin
        if (bus.m_A !== 8'(a0 + nacc) || bus.m_RW !== rw) aerr++;
        nacc++;
      end
      if (bus.done) begin
        lat = k;
        mis = bus.misalign;
        rd  = bus.rd_data;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.req_E = 1'b0;
  endtask

  initial begin
    int lat, stalls, nacc, aerr, d1, d2;
    logic mis;
    logic [31:0] rd;

    checks = 0;
    failures = 0;
    pre_we = 1'b0;
    pre_a = '0;
    pre_d = '0;
    bus.req_E = 1'b0;
    bus.req_RW = 1'b0;
    bus.req_Size = 1'b0;
    bus.req_A = '0;
    bus.req_DI = '0;

    vt[0] = '{1'b0, 1'b1, 8'd52, 32'h0,        32'h12345678, 1'b0, 5, 8'd52, 4};
    vt[1] = '{1'b0, 1'b0, 8'd56, 32'h0,        32'h000000F0, 1'b0, 2, 8'd56, 1};
    vt[2] = '{1'b1, 1'b0, 8'd58, 32'hDEADBEAB, 32'h000000F0, 1'b0, 2, 8'd58, 1};
    vt[3] = '{1'b0, 1'b1, 8'd53, 32'h0,        32'h12345678, 1'b1, 5, 8'd52, 4};
    vt[4] = '{1'b0, 1'b0, 8'd57, 32'h0,        32'h0000005A, 1'b0, 2, 8'd57, 1};
    vt[5] = '{1'b1, 1'b1, 8'd61, 32'h01020304, 32'h0000005A, 1'b1, 5, 8'd60, 4};
    vt[6] = '{1'b0, 1'b1, 8'd60, 32'h0,        32'h01020304, 1'b0, 5, 8'd60, 4};

    R = 1'b1;
    poke(8'd52, 8'h12);
    poke(8'd53, 8'h34);
    poke(8'd54, 8'h56);
    poke(8'd55, 8'h78);
    poke(8'd56, 8'hF0);
    poke(8'd57, 8'h5A);
    poke(8'd58, 8'h11);
    poke(8'd59, 8'h77);
    for (int i = 0; i < 4; i++) begin
      poke(8'(i), 8'h00);
      poke(8'(60 + i), 8'h00);
    end

    bus.req_E = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_m_E", 32'(bus.m_E), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    @(posedge clk);
    #1;
    bus.req_E = 1'b0;
    R = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_req(vt[i].rw, vt[i].size, vt[i].a, vt[i].di, vt[i].exp_a0,
              lat, stalls, nacc, aerr, mis, rd);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d_stalls", i), 32'(stalls), 32'(vt[i].exp_lat));
      chk($sformatf("v%0d_naccess", i), 32'(nacc), 32'(vt[i].exp_n));
      chk($sformatf("v%0d_addr_rw", i), 32'(aerr), 32'd0);
      chk($sformatf("v%0d_misalign", i), 32'(mis), 32'(vt[i].exp_mis));
      chk($sformatf("v%0d_rd_data", i), rd, vt[i].exp_rd);
    end

    chk("ram57", 32'(ram[57]), 32'h5A);
    chk("ram58", 32'(ram[58]), 32'hAB);
    chk("ram59", 32'(ram[59]), 32'h77);
    chk("ram60", 32'(ram[60]), 32'h01);
    chk("ram61", 32'(ram[61]), 32'h02);
    chk("ram62", 32'(ram[62]), 32'h03);
    chk("ram63", 32'(ram[63]), 32'h04);

    // Word store A=0 interrupted by reset after two XFER cycles
    bus.req_E    = 1'b1;
    bus.req_RW   = 1'b1;
    bus.req_Size = 1'b1;
    bus.req_A    = 8'd0;
    bus.req_DI   = 32'hAABBCCDD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    R = 1'b1;
    @(negedge clk);
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    chk("midrst_m_E", 32'(bus.m_E), 32'd0);
    @(posedge clk);
    #1;
    R = 1'b0;
    bus.req_E = 1'b0;
    @(negedge clk);
    chk("midrst_idle_stall", 32'(bus.stall), 32'd0);
    chk("midrst_idle_done", 32'(bus.done), 32'd0);
    chk("midrst_rd_data", bus.rd_data, 32'd0);
    chk("midrst_ram0", 32'(ram[0]), 32'hAA);
    chk("midrst_ram1", 32'(ram[1]), 32'hBB);
    chk("midrst_ram2", 32'(ram[2]), 32'h00);
    chk("midrst_ram3", 32'(ram[3]), 32'h00);
    @(posedge clk);
    #1;
    run_req(1'b0, 1'b0, 8'd56, 32'h0, 8'd56,
            lat, stalls, nacc, aerr, mis, rd);
    chk("postrst_latency", 32'(lat), 32'd2);
    chk("postrst_rd_data", rd, 32'h000000F0);

    // Word read held through DONE, then byte read queued behind it
    bus.req_E    = 1'b1;
    bus.req_RW   = 1'b0;
    bus.req_Size = 1'b1;
    bus.req_A    = 8'd52;
    bus.req_DI   = 32'h0;
    d1 = -1; d2 = -1; nacc = 0; rd = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.m_E) nacc++;
      if (bus.done) begin
        if (d1 < 0) d1 = k;
        else begin
          d2 = k;
          rd = bus.rd_data;
          break;
        end
      end
      @(posedge clk);
      #1;
      if (k == d1) begin
        bus.req_Size = 1'b0;
        bus.req_A    = 8'd57;
      end
    end
    @(posedge clk);
    #1;
    bus.req_E = 1'b0;
    chk("b2b_first_done", 32'(d1), 32'd5);
    chk("b2b_second_done", 32'(d2), 32'd8);
    chk("b2b_naccess", 32'(nacc), 32'd5);
    chk("b2b_rd_data", rd, 32'h0000005A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
